// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 16;

    // Loader FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_LOAD = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_ERR  = 3'd4;

    // Byte address of instruction word 'idx' relative to 'base'
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [IDX_W-1:0] idx);
        return base + {{(30-IDX_W){1'b0}}, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte stream, instruction memory write port and status bundle
//                of the instruction memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic             start;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic             im_we;
    logic [31:0]      im_addr;
    logic [31:0]      im_wdata;
    logic             cpu_hold;
    logic             load_done;
    logic             load_err;
    logic [IDX_W-1:0] words_loaded;

    // Boot controller / stream source side
    modport master (
        output start, in_byte, in_valid,
        input  in_ready, im_we, im_addr, im_wdata,
        input  cpu_hold, load_done, load_err, words_loaded
    );

    // Loader side
    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, im_we, im_addr, im_wdata,
        output cpu_hold, load_done, load_err, words_loaded
    );

endinterface
`default_nettype wire

// File: rtl/imem_loader_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_to_word_packer
//  Description : Assembles big-endian bytes into 32-bit words. The completed
//                word and its strobe are presented combinationally in the
//                cycle the last byte is accepted, so the consumer can act on
//                the same clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_to_word_packer
    import imem_loader_pkg::*;
#(
    parameter int CNT_W = $clog2(WORD_BYTES)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic [7:0]       in_byte,
    input  wire logic             in_valid,
    input  wire logic             accept,
    output logic [31:0]           word,
    output logic                  word_valid,
    output logic [CNT_W-1:0]      byte_cnt
);

    logic [8*(WORD_BYTES-1)-1:0] r_sr;
    logic [CNT_W-1:0]            r_cnt;
    logic                        w_take;

    assign w_take     = in_valid & accept;
    assign word       = {r_sr, in_byte};
    assign word_valid = w_take && (r_cnt == CNT_W'(WORD_BYTES - 1));
    assign byte_cnt   = r_cnt;

    // Shift accepted bytes in and count position within the word; a partial word holds while idle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_sr  <= {r_sr[8*(WORD_BYTES-2)-1:0], in_byte};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction memory writer. Reads a word count N
//                followed by N big-endian instruction words from a byte
//                stream, writes them to consecutive word addresses and holds
//                the CPU until the load completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'd0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    imem_loader_if.slave  bus
);

    state_t           r_state;
    logic [31:0]      r_n;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_words;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_done;

    logic             w_in_ready;
    logic             w_start_ok;
    logic [31:0]      w_word;
    logic             w_word_valid;
    logic [1:0]       w_byte_cnt;
    logic             w_last_idx;

    assign w_in_ready = (r_state == ST_HDR) || (r_state == ST_LOAD);
    assign w_start_ok = bus.start &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_last_idx = ({{(32-IDX_W){1'b0}}, r_index} == (r_n - 32'd1));

    byte_to_word_packer #(
        .CNT_W (2)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_start_ok),
        .in_byte    (bus.in_byte),
        .in_valid   (bus.in_valid),
        .accept     (w_in_ready),
        .word       (w_word),
        .word_valid (w_word_valid),
        .byte_cnt   (w_byte_cnt)
    );

    // Load sequencing: header decode, one write per completed word, done/error entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_index <= '0;
            r_words <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.start) begin
                        r_state <= ST_HDR;
                        r_index <= '0;
                        r_words <= '0;
                    end
                end
                ST_HDR: begin
                    if (w_word_valid) begin
                        r_n <= w_word;
                        if (w_word == 32'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (w_word > 32'(DEPTH_WORDS)) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_word_valid) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_word;
                        r_addr  <= word_addr(BASE_ADDR, r_index);
                        r_index <= r_index + IDX_W'(1);
                        r_words <= r_words + IDX_W'(1);
                        if (w_last_idx) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.im_we        = r_we;
    assign bus.im_addr      = r_addr;
    assign bus.im_wdata     = r_wdata;
    assign bus.cpu_hold     = (r_state != ST_DONE);
    assign bus.load_done    = r_done;
    assign bus.load_err     = (r_state == ST_ERR);
    assign bus.words_loaded = r_words;

    // Byte position is only of interest for debug visibility
    logic w_unused;
    assign w_unused = ^w_byte_cnt;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory that the fetch stage reads. It accepts a big-endian byte stream through a valid/ready handshake and assembles 32-bit words. The first word is a word count N; it then writes N instruction words to consecutive word addresses through the instruction memory write port. The pipeline is held in stall until the load completes.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in words; headers with N > DEPTH_WORDS are rejected
BASE_ADDR, 32'd0, byte address of the first instruction written; word aligned

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  begin a load; honoured only in IDLE, DONE or ERR
in_byte  input  8  stream byte; the first byte of each word is bits [31:24]
in_valid  input  1  in_byte is valid
in_ready  output  1  loader accepts a byte this cycle
im_we  output  1  instruction memory write strobe, one-cycle pulse per word
im_addr  output  32  byte address of the write; BASE_ADDR + 4*index
im_wdata  output  32  assembled instruction word
cpu_hold  output  1  stalls PC/IF_ID update while high
load_done  output  1  one-cycle pulse on entry to DONE
load_err  output  1  level, high while in ERR
words_loaded  output  16  count of words written in the current load

Behaviour:
- Reset, sampled on the clk edge:
  - state = IDLE; byte_cnt = 0; index = 0; N = 0.
  - in_ready = 0; im_we = 0; im_addr = 0; im_wdata = 0.
  - cpu_hold = 1; load_done = 0; load_err = 0; words_loaded = 0.
- Byte transfer: a byte is accepted on a cycle where in_valid & in_ready. in_ready is high only in HDR and LOAD.
- Word assembly: shift register, word = {word[23:0], in_byte}. byte_cnt runs 0..3 and wraps to 0 after the 4th byte.
- States:
  - IDLE: cpu_hold = 1. On start -> HDR, clearing byte_cnt, index and words_loaded.
  - HDR: on the 4th accepted byte, latch N = assembled word.
    - N == 0 -> DONE.
    - N > DEPTH_WORDS -> ERR.
    - otherwise -> LOAD.
  - LOAD: on the 4th accepted byte, on the next edge:
    - im_we = 1, im_wdata = word, im_addr = BASE_ADDR + (index << 2);
    - index and words_loaded increment.
    - im_we is 0 on all other cycles.
    - When the write of word index N-1 is issued -> DONE on the same edge; in_ready drops that cycle.
  - DONE: cpu_hold = 0, in_ready = 0, load_done high exactly one cycle. On start -> HDR (reload).
  - ERR: cpu_hold = 1, load_err = 1, in_ready = 0, no writes. On start -> HDR, clearing load_err.
- start while in HDR or LOAD is ignored; it causes no abort.
- Write latency: im_we rises exactly one clk after the cycle accepting a word's 4th byte.
- Maximum throughput: one byte per cycle.
- Back-to-back words: writes may occur on consecutive 4-cycle boundaries. No stall is ever applied to the write port, because the memory write accepts every cycle.
- Partial word: in_valid deasserting mid-word holds byte_cnt and the partial word indefinitely. There is no timeout.
- Reset mid-load returns to IDLE with cpu_hold = 1. Words already written stay in memory; no rollback.
- Address arithmetic: 32-bit and unsigned. index is 16 bits wide; N <= DEPTH_WORDS <= 65535.
- in_byte is ignored whenever in_ready = 0.

Decomposition:
- Shared package `imem_loader_pkg`:
  - state enum: IDLE, HDR, LOAD, DONE, ERR;
  - localparams WORD_BYTES = 4 and IDX_W = 16.
- One sub-module, `byte_to_word_packer`: in_byte/in_valid/accept -> word, word_valid pulse, byte_cnt.
  - Has a clear input driven on start.
  - The FSM and write port live in the top.

Test Plan:
- rst held 2 cycles -> cpu_hold = 1, in_ready = 0, im_we = 0. start, then stream 00 00 00 02 | 24 08 00 05 | 20 09 00 07:
  - im_we pulses twice: addr 0x0 / data 0x24080005, then addr 0x4 / data 0x20090007;
  - load_done pulses once; cpu_hold = 0.
- Header 00 00 00 00 -> DONE directly with no im_we; words_loaded = 0; load_done pulses once.
- DEPTH_WORDS = 256, header 00 00 01 01 (N = 257):
  - -> ERR, load_err = 1, in_ready = 0, cpu_hold = 1;
  - a following start with a valid header clears load_err and loads normally.
- Gapped stream: in_valid toggles with random gaps, including mid-word, for N = 3:
  - data and address match the gap-free run;
  - im_we count = 3; each im_we is exactly 1 cycle after its 4th byte's accept.
- rst asserted after 5 bytes of a load -> IDLE, cpu_hold = 1, words_loaded = 0. start and a fresh N = 1 stream writes correctly at BASE_ADDR.
- BASE_ADDR = 32'h40, N = 2 -> addresses 0x40 and 0x44. A start pulse during LOAD has no effect on the sequence.
